// File: rtl/riscv_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_hazard_ctrl_pkg
//
// Shared encodings for the pipeline hazard controller:
//   - execute-stage forward-select codes (FWD_RF / FWD_WB / FWD_MEM)
//   - result-source code that marks a load in execute (RES_LOAD)
//   - multicycle sequencer state encoding (mc_state_t)
//   - fwd_select(): the per-operand forwarding priority function
// ---------------------------------------------------------------------------
package riscv_hazard_ctrl_pkg;

    // Operand select driven to the execute-stage operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;  // register-file value
    localparam logic [1:0] FWD_WB  = 2'b01;  // result_w from writeback
    localparam logic [1:0] FWD_MEM = 2'b10;  // alu_result_m from memory stage

    // result_src value that identifies a load in execute.
    localparam logic [1:0] RES_LOAD = 2'b01;

    // Multicycle sequencer states.
    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    // Forwarding priority for one execute source register.
    // The memory stage holds the younger result, so it wins over writeback.
    // x0 is hard-wired to zero and must never pick up a forwarded value.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != 5'd0) begin
            if (reg_write_m && (rd_m == rs)) begin
                sel = FWD_MEM;
            end else if (reg_write_w && (rd_w == rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/riscv_hazard_ctrl_mc_seq.sv
// ---------------------------------------------------------------------------
// riscv_mc_seq
//
// Fixed-latency multicycle sequencer. Holds the execute stage while an
// iterative unit (e.g. M-extension multiply/divide) works on its operands.
//
// Parameters:
//   MC_LAT  cycles from start to result-valid (>= 2)
//   CNT_W   down-counter width (2**CNT_W > MC_LAT)
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   mc_op     in   instruction in execute is a multicycle op
//   mc_stall  out  hold F, D and E; bubble into M
//   mc_start  out  one-cycle pulse, unit captures forwarded operands
//   mc_busy   out  sequencer is in BUSY (this is the FSM state bit)
//   mc_done   out  one-cycle pulse, result valid this cycle
//
// Timeline for an op first seen at t0:
//   t0            IDLE, start + stall, counter loaded with MC_LAT-1
//   t1..tMC_LAT-1 BUSY, counter nonzero, stall, counter decrements
//   tMC_LAT       BUSY, counter zero, done, no stall; execute advances
// ---------------------------------------------------------------------------
module riscv_mc_seq
    import riscv_hazard_ctrl_pkg::*;
#(
    parameter int MC_LAT = 32,
    parameter int CNT_W  = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic mc_op,
    output logic mc_stall,
    output logic mc_start,
    output logic mc_busy,
    output logic mc_done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mc_state_t        state_q;
    mc_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_stall = 1'b0;
        mc_start = 1'b0;
        mc_done  = 1'b0;

        unique case (state_q)
            MC_IDLE: begin
                // Stall already in the start cycle so the op stays in execute.
                if (mc_op) begin
                    mc_start = 1'b1;
                    mc_stall = 1'b1;
                    cnt_d    = CNT_LOAD;
                    state_d  = MC_BUSY;
                end
            end
            MC_BUSY: begin
                // mc_op is ignored here: it still reflects the same held op.
                if (cnt_q != '0) begin
                    mc_stall = 1'b1;
                    cnt_d    = cnt_q - CNT_ONE;
                end else begin
                    // Stall drops so the op leaves execute at this edge.
                    mc_done = 1'b1;
                    state_d = MC_IDLE;
                end
            end
            default: begin
                state_d = MC_IDLE;
            end
        endcase
    end

    // The busy output is the FSM state itself, which keeps the state
    // observable at the top-level ports.
    assign mc_busy = (state_q == MC_BUSY);

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_hazard_ctrl
//
// Hazard and sequencing controller for the five-stage RISC-V pipeline.
// Produces execute-stage forwarding selects, the load-use stall, the branch
// flush, and the execute hold for fixed-latency multicycle operations.
//
// Parameters:
//   MC_LAT  cycles a multicycle op needs from start to result-valid (>= 2)
//   CNT_W   multicycle counter width (2**CNT_W > MC_LAT)
//
// Ports:
//   i_clk, i_rst                     clock / synchronous active-high reset
//   i_rs1_d, i_rs2_d                 decode source registers
//   i_rs1_e, i_rs2_e, i_rd_e         execute source / destination registers
//   i_result_src_e                   execute result select (RES_LOAD = load)
//   i_reg_write_m, i_rd_m            memory-stage write enable / destination
//   i_reg_write_w, i_rd_w            writeback-stage write enable / destination
//   i_pc_src_e                       taken branch / jump resolved in execute
//   i_mc_op_e                        execute holds a multicycle op
//   o_forward_ae, o_forward_be       operand selects (FWD_RF/FWD_WB/FWD_MEM)
//   o_stall_f, o_stall_d, o_stall_e  hold PC, F/D, D/E
//   o_flush_d, o_flush_e, o_flush_m  bubble F/D, D/E, E/M
//   o_mc_start, o_mc_busy, o_mc_done multicycle start pulse / busy / done pulse
//
// Everything except the multicycle sequencer is combinational and valid in
// the same cycle as its inputs.
// ---------------------------------------------------------------------------
module riscv_hazard_ctrl
    import riscv_hazard_ctrl_pkg::*;
#(
    parameter int MC_LAT = 32,
    parameter int CNT_W  = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_rs1_d,
    input  logic [4:0] i_rs2_d,
    input  logic [4:0] i_rs1_e,
    input  logic [4:0] i_rs2_e,
    input  logic [4:0] i_rd_e,
    input  logic [1:0] i_result_src_e,
    input  logic       i_reg_write_m,
    input  logic [4:0] i_rd_m,
    input  logic       i_reg_write_w,
    input  logic [4:0] i_rd_w,
    input  logic       i_pc_src_e,
    input  logic       i_mc_op_e,
    output logic [1:0] o_forward_ae,
    output logic [1:0] o_forward_be,
    output logic       o_stall_f,
    output logic       o_stall_d,
    output logic       o_stall_e,
    output logic       o_flush_d,
    output logic       o_flush_e,
    output logic       o_flush_m,
    output logic       o_mc_start,
    output logic       o_mc_busy,
    output logic       o_mc_done
);

    logic lw_stall;
    logic mc_stall;

    // ---------------- forwarding ----------------
    assign o_forward_ae = fwd_select(i_rs1_e, i_reg_write_m, i_rd_m,
                                     i_reg_write_w, i_rd_w);
    assign o_forward_be = fwd_select(i_rs2_e, i_reg_write_m, i_rd_m,
                                     i_reg_write_w, i_rd_w);

    // ---------------- load-use hazard ----------------
    // A load in execute has no data until the end of memory, so a dependent
    // instruction in decode must wait one cycle. x0 writes are discarded and
    // never create a dependency.
    assign lw_stall = (i_result_src_e == RES_LOAD) &&
                      (i_rd_e != 5'd0) &&
                      ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

    // ---------------- multicycle sequencer ----------------
    riscv_mc_seq #(
        .MC_LAT (MC_LAT),
        .CNT_W  (CNT_W)
    ) u_mc_seq (
        .clk      (i_clk),
        .rst      (i_rst),
        .mc_op    (i_mc_op_e),
        .mc_stall (mc_stall),
        .mc_start (o_mc_start),
        .mc_busy  (o_mc_busy),
        .mc_done  (o_mc_done)
    );

    // ---------------- output combination ----------------
    assign o_stall_f = lw_stall | mc_stall;
    assign o_stall_d = lw_stall | mc_stall;
    assign o_stall_e = mc_stall;
    assign o_flush_d = i_pc_src_e;
    // While execute is held the D/E register must keep its contents, so the
    // flush into execute is suppressed; the bubble goes into memory instead.
    assign o_flush_e = (lw_stall | i_pc_src_e) & ~mc_stall;
    assign o_flush_m = mc_stall;

endmodule

// File: doc/riscv_hazard_ctrl.md
# riscv_hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RISC-V core. It generates the execute-stage forwarding selects and the load-use stall and branch flush controls. It also holds the execute stage for a fixed-latency multicycle operation, such as an iterative M-extension multiply or divide. It sits beside the execute stage and drives stall and flush inputs on the F/D, D/E and E/M pipeline registers.

## Interface
- MC_LAT, 32, cycles a multicycle operation needs from start to result-valid; must be at least 2.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > MC_LAT.

- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_rs1_d, i_rs2_d  in  5  source registers of the instruction in decode.
- i_rs1_e, i_rs2_e, i_rd_e  in  5  source and destination registers of the instruction in execute.
- i_result_src_e  in  2  result select in execute; 2'b01 marks a load.
- i_reg_write_m, i_rd_m  in  1/5  memory-stage writeback enable and destination.
- i_reg_write_w, i_rd_w  in  1/5  writeback-stage enable and destination.
- i_pc_src_e  in  1  taken branch or jump resolved in execute.
- i_mc_op_e  in  1  the instruction in execute is a multicycle operation.
- o_forward_ae, o_forward_be  out  2  operand select: 00 register file, 01 result_w, 10 alu_result_m.
- o_stall_f, o_stall_d, o_stall_e  out  1  hold the PC, the F/D register and the D/E register.
- o_flush_d, o_flush_e, o_flush_m  out  1  bubble the F/D, D/E and E/M registers.
- o_mc_start  out  1  one-cycle pulse; the multicycle unit captures the forwarded operands.
- o_mc_busy  out  1  the FSM is in BUSY.
- o_mc_done  out  1  one-cycle pulse; the multicycle result is valid this cycle.

## Operation
- Forwarding is combinational and applies to each source independently:
  - Select 10 when i_reg_write_m is set and i_rd_m equals rs_e, which must be nonzero.
  - Otherwise select 01 when i_reg_write_w is set and i_rd_w equals rs_e, which must be nonzero.
  - Otherwise select 00.
  - The memory stage has priority over writeback. x0 never forwards.
- Load-use hazard, lw_stall:
  - Condition: i_result_src_e is 01, i_rd_e is nonzero, and i_rd_e equals i_rs1_d or i_rs2_d.
  - Response: assert stall_f, stall_d and flush_e.
- Branch: i_pc_src_e asserts flush_d and flush_e.
- Multicycle FSM, with states IDLE and BUSY and a down-counter cnt:
  - IDLE with i_mc_op_e set:
    - Assert o_mc_start and mc_stall.
    - Load cnt with MC_LAT-1 and go to BUSY.
  - BUSY with cnt nonzero: assert mc_stall and decrement cnt.
  - BUSY with cnt equal to 0:
    - Deassert mc_stall and pulse o_mc_done.
    - Go to IDLE; the execute instruction advances at this edge.
  - mc_stall asserts stall_f, stall_d, stall_e and flush_m. flush_m keeps a bubble entering the memory stage while execute holds.
- Output combination:
  - o_stall_f and o_stall_d are lw_stall OR mc_stall.
  - o_stall_e is mc_stall.
  - o_flush_e is (lw_stall OR i_pc_src_e) AND NOT mc_stall.
  - o_flush_m is mc_stall.
- Simultaneous events:
  - A load or branch cannot coexist with i_mc_op_e for the same execute instruction.
  - While BUSY, the decode comparison is frozen, so lw_stall cannot fire.
  - i_mc_op_e is ignored while BUSY.
- Back-to-back multicycle ops: the second op enters execute on the cycle after o_mc_done and starts immediately from IDLE.

## Timing
- Reset: on an edge with i_rst set, the state goes to IDLE and cnt to 0.
  - The next cycle has o_mc_busy, o_mc_start and o_mc_done at 0, and every stall and flush at 0 unless the inputs demand one.
  - A reset mid-BUSY aborts the operation with no o_mc_done.
- Forwarding, lw_stall and branch flush have zero latency and are valid in the same cycle as their inputs.
- Multicycle op with i_mc_op_e first seen at t0:
  - o_mc_start at t0 only.
  - mc_stall from t0 through t(MC_LAT-1).
  - o_mc_busy from t1 through tMC_LAT.
  - o_mc_done at tMC_LAT.
  - Total residency in execute is MC_LAT+1 cycles.
- Forwarding selects are valid at t0 for operand capture. The datapath must not depend on them after o_mc_start.

## Structure
- Shared package or config include:
  - Forward-select encodings FWD_RF, FWD_WB and FWD_MEM.
  - Result-source encoding RES_LOAD = 2'b01.
  - FSM state encodings.
- One sub-module, riscv_mc_seq: the FSM, the counter, and mc_stall, o_mc_start, o_mc_busy and o_mc_done.
- Forwarding and hazard equations stay in the top level.

## Test plan
- Forwarding priority:
  - i_reg_write_m=1, i_rd_m=5, i_reg_write_w=1, i_rd_w=5, i_rs1_e=5 → o_forward_ae=10.
  - Deassert i_reg_write_m → 01.
  - Drive i_rs1_e=0 with i_rd_m=0 → 00.
- Load-use: i_result_src_e=01, i_rd_e=7, i_rs2_d=7 → o_stall_f=o_stall_d=o_flush_e=1 for one cycle; i_rd_e=0 → no stall.
- Branch: i_pc_src_e=1 for one cycle → o_flush_d=o_flush_e=1 with all stalls at 0.
- Multicycle with MC_LAT=4, i_mc_op_e held high:
  - o_mc_start at t0.
  - o_stall_e and o_flush_m at t0 through t3.
  - o_mc_busy at t1 through t4.
  - o_mc_done at t4.
  - A second op presented at t5 → o_mc_start at t5.
- Reset at t2 of BUSY:
  - The cycle after the reset edge has o_mc_busy=0 and no stalls.
  - o_mc_done never pulses.
  - A new i_mc_op_e restarts the full MC_LAT sequence.
